// File: rtl/gray_pkg.sv
// Shared helpers for the Gray-code counter: direction encodings and
// binary/Gray conversion functions sized for the widest legal counter.
package gray_pkg;

  // Widest counter the helpers support; narrower values are zero-extended.
  localparam int MAX_WIDTH = 16;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Binary to Gray: each Gray bit is the XOR of a binary bit and its upper neighbour.
  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: prefix XOR from the MSB down. Zero-extended upper bits
  // contribute nothing, so the result is valid for any narrower width.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_code_counter.sv
// Up/down binary counter with a registered Gray-code image, synchronous
// load and a one-cycle wrap pulse. The Gray output comes straight from a
// flop so it can be sampled safely from another clock domain.
module gray_code_counter
  import gray_pkg::*;
#(
  parameter int          WIDTH       = 4,
  parameter int unsigned RESET_VALUE = 32'd0
) (
  input  logic             Clock_In,
  input  logic             Reset_In,
  input  logic             Enable_In,
  input  logic             Up_Down_In,
  input  logic             Load_In,
  input  logic [WIDTH-1:0] Load_Data_In,
  output logic [WIDTH-1:0] Binary_Data_Out,
  output logic [WIDTH-1:0] Gray_Data_Out,
  output logic             Wrap_Out
);

  localparam logic [WIDTH-1:0]     RESET_BIN    = RESET_VALUE[WIDTH-1:0];
  localparam logic [MAX_WIDTH-1:0] RESET_GRAY_W = bin2gray(MAX_WIDTH'(RESET_BIN));
  localparam logic [WIDTH-1:0]     RESET_GRAY   = RESET_GRAY_W[WIDTH-1:0];
  localparam logic [WIDTH-1:0]     MAX_COUNT    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]     ONE          = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]     ZERO         = {WIDTH{1'b0}};

  logic [WIDTH-1:0]     bin_r;
  logic [WIDTH-1:0]     gray_r;
  logic                 wrap_r;

  logic [WIDTH-1:0]     next_bin_s;
  logic [MAX_WIDTH-1:0] next_gray_wide_s;
  logic [WIDTH-1:0]     next_gray_s;
  logic                 next_wrap_s;

  // Next-state selection: load beats count, count beats hold; the Gray image
  // is derived from the next binary value so both registers stay in step.
  always_comb begin
    next_bin_s  = bin_r;
    next_wrap_s = 1'b0;
    if (Load_In) begin
      next_bin_s  = Load_Data_In;
      next_wrap_s = 1'b0;
    end else if (Enable_In) begin
      if (Up_Down_In == DIR_UP) begin
        next_bin_s  = bin_r + ONE;
        next_wrap_s = (bin_r == MAX_COUNT);
      end else begin
        next_bin_s  = bin_r - ONE;
        next_wrap_s = (bin_r == ZERO);
      end
    end else begin
      next_bin_s  = bin_r;
      next_wrap_s = 1'b0;
    end
    next_gray_wide_s = bin2gray(MAX_WIDTH'(next_bin_s));
    next_gray_s      = next_gray_wide_s[WIDTH-1:0];
  end

  // State register for binary count, Gray image and wrap pulse; reset wins over everything.
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      bin_r  <= RESET_BIN;
      gray_r <= RESET_GRAY;
      wrap_r <= 1'b0;
    end else begin
      bin_r  <= next_bin_s;
      gray_r <= next_gray_s;
      wrap_r <= next_wrap_s;
    end
  end

  assign Binary_Data_Out = bin_r;
  assign Gray_Data_Out   = gray_r;
  assign Wrap_Out        = wrap_r;

endmodule

// File: tb/tb_gray_code_counter.sv
// Directed and randomised self-checking bench for gray_code_counter (WIDTH = 4).
module tb_gray_code_counter;
  import gray_pkg::*;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       ld;
  logic [3:0] ld_data;
  logic [3:0] bin_q;
  logic [3:0] gray_q;
  logic       wrap_q;

  int pass_cnt  = 0;
  int total_cnt = 0;

  gray_code_counter #(.WIDTH(4), .RESET_VALUE(32'd0)) dut (
    .Clock_In        (clk),
    .Reset_In        (rst),
    .Enable_In       (en),
    .Up_Down_In      (up),
    .Load_In         (ld),
    .Load_Data_In    (ld_data),
    .Binary_Data_Out (bin_q),
    .Gray_Data_Out   (gray_q),
    .Wrap_Out        (wrap_q)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic u, input logic l, input logic [3:0] d);
    rst = r; en = e; up = u; ld = l; ld_data = d;
  endtask

  task automatic check_state(input string tag, input logic [3:0] b, input logic [3:0] g, input logic w);
    check({tag, "_bin"}, 32'(bin_q), 32'(b));
    check({tag, "_gray"}, 32'(gray_q), 32'(g));
    check({tag, "_wrap"}, 32'(wrap_q), 32'(w));
  endtask

  logic [3:0] gray_up_tbl [16];
  logic [3:0] down_bin_tbl [5];
  logic [3:0] down_gray_tbl [5];

  logic [3:0] mb;
  logic [3:0] mb_next;
  logic       mw_next;
  logic [3:0] prev_g;
  logic       count_edge;

  initial begin
    gray_up_tbl = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                    4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    down_bin_tbl  = '{4'h2, 4'h1, 4'h0, 4'hF, 4'hE};
    down_gray_tbl = '{4'h3, 4'h1, 4'h0, 4'h8, 4'h9};

    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    #2;

    // 1. Reset for two edges, then count up through the wrap.
    step();
    step();
    check_state("reset", 4'h0, 4'h0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 16; i++) begin
      step();
      check_state($sformatf("up%0d", i), 4'((i + 1) % 16), gray_up_tbl[i], (i == 15));
    end

    // 2. Load 3, then count down across zero.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'h3);
    step();
    check_state("load3", 4'h3, 4'h2, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_state($sformatf("down%0d", i), down_bin_tbl[i], down_gray_tbl[i], (i == 3));
    end

    // 3. Load and enable together: load wins.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h9);
    step();
    check_state("load_en", 4'h9, 4'hD, 1'b0);

    // Load max, no wrap; next up step wraps.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'hF);
    step();
    check_state("load_max", 4'hF, 4'h8, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    step();
    check_state("max_wrap", 4'h0, 4'h0, 1'b1);

    // 4. Hold at 6 for three edges.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'h5);
    step();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    step();
    check_state("to6", 4'h6, 4'h5, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'hA);
    for (int i = 0; i < 3; i++) begin
      step();
      check_state($sformatf("hold%0d", i), 4'h6, 4'h5, 1'b0);
    end

    // 5. Reset on the edge that would wrap up from 0xF.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'hF);
    step();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    step();
    check_state("rst_wrap", 4'h0, 4'h0, 1'b0);

    // 6. Random Enable/Up_Down/Load/Reset against a reference model.
    mb = 4'h0;
    for (int i = 0; i < 200; i++) begin
      drive(($urandom_range(31) == 0), 1'($urandom_range(1)), 1'($urandom_range(1)),
            ($urandom_range(7) == 0), 4'($urandom_range(15)));
      mw_next    = 1'b0;
      count_edge = 1'b0;
      if (rst) begin
        mb_next = 4'h0;
      end else if (ld) begin
        mb_next = ld_data;
      end else if (en) begin
        count_edge = 1'b1;
        if (up) begin
          mb_next = 4'((int'(mb) + 1) % 16);
          mw_next = (mb == 4'hF);
        end else begin
          mb_next = 4'((int'(mb) + 15) % 16);
          mw_next = (mb == 4'h0);
        end
      end else begin
        mb_next = mb;
      end
      prev_g = gray_q;
      step();
      check("rnd_bin", 32'(bin_q), 32'(mb_next));
      check("rnd_wrap", 32'(wrap_q), 32'(mw_next));
      check("rnd_gray", 32'(gray_q), 32'(mb_next ^ (mb_next >> 1)));
      check("rnd_g2b", 32'(gray2bin(16'(gray_q))), 32'(mb_next));
      if (count_edge) check("rnd_hamming", 32'($countones(prev_g ^ gray_q)), 32'd1);
      mb = mb_next;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
